ppi_core: RTL and testbench

PPI_CORE -- requirements
Module: ppi

---
 rtl/ppi_pkg.sv | 44 ++++
 rtl/ppi_if.sv | 9 +
 rtl/ppi_strobe_port.sv | 62 ++++++
 rtl/ppi_core.sv | 140 ++++++++++++++
 tb/tb_ppi_core.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: register addresses, control-word and status bit positions for ppi_core.
package ppi_pkg;
  localparam int DATA_W = 8;

  localparam logic [2:0] ADDR_PA  = 3'd0;
  localparam logic [2:0] ADDR_PB  = 3'd1;
  localparam logic [2:0] ADDR_PC  = 3'd2;
  localparam logic [2:0] ADDR_CTL = 3'd7;

  localparam int CW_FLAG     = 7;
  localparam int CW_AMODE_HI = 6;
  localparam int CW_AMODE_LO = 5;
  localparam int CW_ADIR     = 4;
  localparam int CW_CUDIR    = 3;
  localparam int CW_BMODE    = 2;
  localparam int CW_BDIR     = 1;
  localparam int CW_CLDIR    = 0;

  localparam logic [7:0] CTRL_RST = 8'h9B;

  localparam int ST_INTEA = 7;
  localparam int ST_IBFA  = 6;
  localparam int ST_INTRA = 5;
  localparam int ST_MODEA = 4;
  localparam int ST_INTEB = 3;
  localparam int ST_IBFB  = 2;
  localparam int ST_INTRB = 1;
  localparam int ST_MODEB = 0;

  function automatic logic [7:0] pack_status(input logic intea, ibfa, intra, modea,
                                             input logic inteb, ibfb, intrb, modeb);
    logic [7:0] st;
    st           = '0;
    st[ST_INTEA] = intea;
    st[ST_IBFA]  = ibfa;
    st[ST_INTRA] = intra;
    st[ST_MODEA] = modea;
    st[ST_INTEB] = inteb;
    st[ST_IBFB]  = ibfb;
    st[ST_INTRB] = intrb;
    st[ST_MODEB] = modeb;
    return st;
  endfunction
endpackage

// File: rtl/ppi_if.sv
// ppi_if: host-side strobe and address lines of the ppi_core register bus.
interface ppi_if;
  logic       rdb;
  logic       wrb;
  logic [2:0] address;

  modport master (output rdb, wrb, address);
  modport slave  (input  rdb, wrb, address);
endinterface

// File: rtl/ppi_strobe_port.sv
// ppi_strobe_port: strobed input latch with IBF/INTR/INTE handshake for one 8-bit port.
module ppi_strobe_port
  import ppi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stb_n,
  input  logic              i_active,
  input  logic [DATA_W-1:0] i_pins,
  input  logic              i_rd_fall,
  input  logic              i_rd_rise,
  input  logic              i_mode_set,
  input  logic              i_inte_we,
  input  logic              i_inte_d,
  output logic [DATA_W-1:0] o_latch,
  output logic              o_ibf,
  output logic              o_intr,
  output logic              o_inte
);
  // [0] first sync flop, [1] synchronized strobe, [2] previous synchronized value
  logic [2:0]        r_stb_sync;
  logic [DATA_W-1:0] r_latch;
  logic              r_ibf, r_intr, r_inte;
  logic              w_stb_fall, w_stb_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stb_sync <= 3'b111;
    else       r_stb_sync <= {r_stb_sync[1:0], i_stb_n};
  end

  assign w_stb_fall = i_active &  r_stb_sync[2] & ~r_stb_sync[1];
  assign w_stb_rise = i_active & ~r_stb_sync[2] &  r_stb_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_latch <= '0;
      r_ibf   <= 1'b0;
      r_intr  <= 1'b0;
      r_inte  <= 1'b0;
    end else if (i_mode_set) begin
      r_ibf   <= 1'b0;
      r_intr  <= 1'b0;
      r_inte  <= 1'b1;
    end else begin
      if (i_inte_we) r_inte <= i_inte_d;
      // a strobe while IBF is set simply overwrites the latch
      if (w_stb_fall) begin
        r_latch <= i_pins;
        r_ibf   <= 1'b1;
      end else if (i_active && i_rd_rise) begin
        r_ibf   <= 1'b0;
      end
      if (w_stb_rise && r_inte && r_ibf) r_intr <= 1'b1;
      else if (i_active && i_rd_fall)    r_intr <= 1'b0;
    end
  end

  assign o_latch = r_latch;
  assign o_ibf   = r_ibf;
  assign o_intr  = r_intr;
  assign o_inte  = r_inte;
endmodule

// File: rtl/ppi_core.sv
// ppi_core: three-port parallel peripheral interface (mode 0 / strobed-input mode 1).
// Optional PortC bit set/reset via control writes with data[7]=0 when PPI_BSR_EN is defined.
module ppi_core
  import ppi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ppi_if.slave              bus,
  inout  wire  [DATA_W-1:0] data,
  inout  wire  [DATA_W-1:0] PortA,
  inout  wire  [DATA_W-1:0] PortB,
  inout  wire  [DATA_W-1:0] PortC
);
  logic [CW_FLAG-1:0] r_ctrl;
  logic [DATA_W-1:0]  r_out_a, r_out_b, r_out_c;
  logic [2:0]         r_rd_sync, r_wr_sync;
  logic               w_wr_rise, w_rd_fall, w_rd_rise, w_mode_set;
  logic               w_mode_a, w_mode_b, w_a_in, w_b_in;
  logic               w_inte_a_we, w_inte_b_we;
  logic [DATA_W-1:0]  w_latch_a, w_latch_b, w_rd, w_c_oe, w_c_out;
  logic               w_ibf_a, w_intr_a, w_inte_a, w_ibf_b, w_intr_b, w_inte_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_sync <= 3'b111;
      r_wr_sync <= 3'b111;
    end else begin
      r_rd_sync <= {r_rd_sync[1:0], bus.rdb};
      r_wr_sync <= {r_wr_sync[1:0], bus.wrb};
    end
  end

  // read edges count only while no write is in progress, so a write always wins
  assign w_wr_rise  = r_wr_sync[1] & ~r_wr_sync[2];
  assign w_rd_fall  = r_rd_sync[2] & ~r_rd_sync[1] & r_wr_sync[1];
  assign w_rd_rise  = ~r_rd_sync[2] & r_rd_sync[1] & r_wr_sync[1];
  assign w_mode_set = w_wr_rise & (bus.address == ADDR_CTL) & data[CW_FLAG];

  assign w_mode_a = |r_ctrl[CW_AMODE_HI:CW_AMODE_LO];
  assign w_mode_b = r_ctrl[CW_BMODE];
  assign w_a_in   = r_ctrl[CW_ADIR];
  assign w_b_in   = r_ctrl[CW_BDIR];

`ifdef PPI_BSR_EN
  logic w_bsr;
  assign w_bsr       = w_wr_rise & (bus.address == ADDR_CTL) & ~data[CW_FLAG];
  assign w_inte_a_we = w_bsr & (data[3:1] == 3'd4) & w_mode_a;
  assign w_inte_b_we = w_bsr & (data[3:1] == 3'd2) & w_mode_b;
`else
  assign w_inte_a_we = 1'b0;
  assign w_inte_b_we = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl  <= CTRL_RST[CW_FLAG-1:0];
      r_out_a <= '0;
      r_out_b <= '0;
      r_out_c <= '0;
    end else if (w_wr_rise) begin
      case (bus.address)
        ADDR_PA: r_out_a <= data;
        ADDR_PB: r_out_b <= data;
        ADDR_PC: r_out_c <= data;
        ADDR_CTL: begin
          if (data[CW_FLAG]) begin
            r_ctrl  <= data[CW_FLAG-1:0];
            r_out_a <= '0;
            r_out_b <= '0;
            r_out_c <= '0;
          end
`ifdef PPI_BSR_EN
          else r_out_c[data[3:1]] <= data[0];
`endif
        end
        default: ;
      endcase
    end
  end

  ppi_strobe_port u_port_a (
    .clk(clk), .reset(reset), .i_stb_n(PortC[4]), .i_active(w_mode_a & w_a_in),
    .i_pins(PortA), .i_rd_fall(w_rd_fall & (bus.address == ADDR_PA)),
    .i_rd_rise(w_rd_rise & (bus.address == ADDR_PA)), .i_mode_set(w_mode_set),
    .i_inte_we(w_inte_a_we), .i_inte_d(data[0]), .o_latch(w_latch_a),
    .o_ibf(w_ibf_a), .o_intr(w_intr_a), .o_inte(w_inte_a)
  );

  ppi_strobe_port u_port_b (
    .clk(clk), .reset(reset), .i_stb_n(PortC[2]), .i_active(w_mode_b & w_b_in),
    .i_pins(PortB), .i_rd_fall(w_rd_fall & (bus.address == ADDR_PB)),
    .i_rd_rise(w_rd_rise & (bus.address == ADDR_PB)), .i_mode_set(w_mode_set),
    .i_inte_we(w_inte_b_we), .i_inte_d(data[0]), .o_latch(w_latch_b),
    .o_ibf(w_ibf_b), .o_intr(w_intr_b), .o_inte(w_inte_b)
  );

  // mode 1 claims PC5..PC3 (group A) and PC2..PC0 (group B); only input ports drive IBF/INTR
  always_comb begin
    w_c_oe  = {{4{~r_ctrl[CW_CUDIR]}}, {4{~r_ctrl[CW_CLDIR]}}};
    w_c_out = r_out_c;
    if (w_mode_a) begin
      w_c_oe[5:3] = 3'b000;
      if (w_a_in) begin
        w_c_oe[5]  = 1'b1;
        w_c_oe[3]  = 1'b1;
        w_c_out[5] = w_ibf_a;
        w_c_out[3] = w_intr_a;
      end
    end
    if (w_mode_b) begin
      w_c_oe[2:0] = 3'b000;
      if (w_b_in) begin
        w_c_oe[1]  = 1'b1;
        w_c_oe[0]  = 1'b1;
        w_c_out[1] = w_ibf_b;
        w_c_out[0] = w_intr_b;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      ADDR_PA:  w_rd = !w_a_in ? r_out_a : (w_mode_a ? w_latch_a : PortA);
      ADDR_PB:  w_rd = !w_b_in ? r_out_b : (w_mode_b ? w_latch_b : PortB);
      ADDR_PC:  w_rd = (w_c_oe & w_c_out) | (~w_c_oe & PortC);
      ADDR_CTL: w_rd = pack_status(w_inte_a, w_ibf_a, w_intr_a, w_mode_a,
                                   w_inte_b, w_ibf_b, w_intr_b, w_mode_b);
      default:  w_rd = '0;
    endcase
  end

  assign data  = (!reset && !bus.rdb && bus.wrb) ? w_rd : {DATA_W{1'bz}};
  assign PortA = !w_a_in ? r_out_a : {DATA_W{1'bz}};
  assign PortB = !w_b_in ? r_out_b : {DATA_W{1'bz}};

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pc
    assign PortC[gi] = w_c_oe[gi] ? w_c_out[gi] : 1'bz;
  end
endmodule

// File: tb/tb_ppi_core.sv
// tb_ppi_core: directed bench for ppi_core; undriven bus/port lines are pulled high.
module tb_ppi_core;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tb_data, tb_pa, tb_pb;
  logic       tb_data_en, tb_pa_en, tb_pb_en;
  logic       tb_pc4, tb_pc4_en, tb_pc2, tb_pc2_en;
  logic [7:0] v;
  int         total = 0;
  int         bad   = 0;

  wire [7:0] data, PortA, PortB, PortC;

  ppi_if bus ();

  ppi_core dut (
    .clk(clk), .reset(reset), .bus(bus),
    .data(data), .PortA(PortA), .PortB(PortB), .PortC(PortC)
  );

  assign data     = tb_data_en ? tb_data : 8'bz;
  assign PortA    = tb_pa_en ? tb_pa : 8'bz;
  assign PortB    = tb_pb_en ? tb_pb : 8'bz;
  assign PortC[4] = tb_pc4_en ? tb_pc4 : 1'bz;
  assign PortC[2] = tb_pc2_en ? tb_pc2 : 1'bz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
    pullup (PortA[g]);
    pullup (PortB[g]);
    pullup (PortC[g]);
  end

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.address = a;
    tb_data     = d;
    tb_data_en  = 1'b1;
    bus.wrb     = 1'b0;
    tick(4);
    bus.wrb     = 1'b1;
    tick(4);
    tb_data_en  = 1'b0;
    tick(1);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus.address = a;
    bus.rdb     = 1'b0;
    tick(4);
    d           = data;
    bus.rdb     = 1'b1;
    tick(4);
  endtask

  task automatic strobe_a(input logic [7:0] pins);
    tb_pa = pins;
    tick(2);
    tb_pc4 = 1'b0;
    tick(4);
    tb_pc4 = 1'b1;
    tick(4);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.rdb = 1'b1; bus.wrb = 1'b1; bus.address = 3'd0;
    tb_data = 8'h00; tb_data_en = 1'b0;
    tb_pa = 8'h00; tb_pa_en = 1'b0; tb_pb = 8'h00; tb_pb_en = 1'b0;
    tb_pc4 = 1'b1; tb_pc4_en = 1'b0; tb_pc2 = 1'b1; tb_pc2_en = 1'b0;
    reset = 1'b1;
    tick(3);
    check("rst_data_hiz", data, 8'hFF);
    check("rst_pa_hiz", PortA, 8'hFF);
    check("rst_pb_hiz", PortB, 8'hFF);
    check("rst_pc_hiz", PortC, 8'hFF);
    reset = 1'b0;
    tick(2);
    rd(3'd7, v);
    check("rst_status", v, 8'h00);

    // mode 0, every port an output
    wr(3'd7, 8'h80);
    check("m0_pb_cleared", PortB, 8'h00);
    check("m0_pc_cleared", PortC, 8'h00);
    wr(3'd0, 8'h3C);
    check("m0_pa_drive", PortA, 8'h3C);
    rd(3'd0, v);
    check("m0_pa_read", v, 8'h3C);
    wr(3'd3, 8'h55);
    rd(3'd3, v);
    check("reserved_read", v, 8'h00);
    check("reserved_no_effect", PortA, 8'h3C);

    // both strobes low to a reserved address: no data drive
    bus.address = 3'd3;
    bus.wrb = 1'b0; bus.rdb = 1'b0;
    tick(2);
    check("both_low_data_hiz", data, 8'hFF);
    bus.wrb = 1'b1; bus.rdb = 1'b1;
    tick(4);
    // both strobes low to PortB: the write lands
    bus.address = 3'd1; tb_data = 8'h77; tb_data_en = 1'b1;
    bus.wrb = 1'b0; bus.rdb = 1'b0;
    tick(4);
    bus.wrb = 1'b1; bus.rdb = 1'b1;
    tick(4);
    tb_data_en = 1'b0;
    tick(1);
    check("both_low_write", PortB, 8'h77);

`ifdef PPI_BSR_EN
    wr(3'd7, 8'h0F);
    check("bsr_set_pc7", PortC, 8'h80);
    wr(3'd7, 8'h0E);
    check("bsr_clr_pc7", PortC, 8'h00);
`else
    wr(3'd7, 8'h0F);
    check("bsr_ignored_pc", PortC, 8'h00);
    check("bsr_ignored_pa", PortA, 8'h3C);
`endif

    // mode 1, both groups strobed inputs
    wr(3'd7, 8'hFF);
    rd(3'd7, v);
    check("m1_status_init", v, 8'h99);
    check("m1_pc_idle", PortC, 8'hD4);
    tb_pa_en = 1'b1; tb_pc4_en = 1'b1;
    strobe_a(8'hA5);
    check("m1_a_ibf_intr_pins", PortC, 8'hFC);
    rd(3'd7, v);
    check("m1_status_a_full", v, 8'hF9);
    tb_pa = 8'h11;
    tick(4);
    rd(3'd0, v);
    check("m1_a_read_latch", v, 8'hA5);
    check("m1_a_cleared_pins", PortC, 8'hD4);

    strobe_a(8'h5A);
    strobe_a(8'h66);
    rd(3'd7, v);
    check("m1_a_double_status", v, 8'hF9);
    rd(3'd0, v);
    check("m1_a_overwrite", v, 8'h66);

    tb_pb_en = 1'b1; tb_pb = 8'hBA; tb_pc2_en = 1'b1;
    tick(2);
    tb_pc2 = 1'b0;
    tick(4);
    tb_pc2 = 1'b1;
    tick(4);
    check("m1_b_ibf_intr_pins", PortC, 8'hD7);
    rd(3'd1, v);
    check("m1_b_read_latch", v, 8'hBA);
    rd(3'd7, v);
    check("m1_b_ibf_cleared", v, 8'h99);

`ifdef PPI_BSR_EN
    wr(3'd7, 8'h08);
    rd(3'd7, v);
    check("bsr_intea_off", v, 8'h19);
    strobe_a(8'h33);
    rd(3'd7, v);
    check("bsr_no_intra", v, 8'h59);
    check("bsr_no_intra_pins", PortC, 8'hF4);
`endif

    // reset mid-run releases every driver and clears status
    tb_pa_en = 1'b0; tb_pb_en = 1'b0; tb_pc4_en = 1'b0; tb_pc2_en = 1'b0;
    reset = 1'b1;
    tick(2);
    check("rst2_pc_hiz", PortC, 8'hFF);
    reset = 1'b0;
    tick(2);
    rd(3'd7, v);
    check("rst2_status", v, 8'h00);
    tb_pa = 8'h6C; tb_pa_en = 1'b1;
    tick(2);
    rd(3'd0, v);
    check("m0_input_live", v, 8'h6C);
    tb_pa = 8'h93;
    tick(2);
    rd(3'd0, v);
    check("m0_input_live2", v, 8'h93);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
